// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin arbitration between NM masters, top-address
// decode onto NS slaves, bus error for unmapped addresses and a watchdog for stalled slaves.
module wb_conbus_rr #(
    parameter int unsigned         NM        = 2,
    parameter int unsigned         NS        = 6,
    parameter int unsigned         AW        = 32,
    parameter int unsigned         DW        = 32,
    parameter int unsigned         DECW      = 4,
    parameter logic [NS*DECW-1:0]  SLV_ADDRS = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h0},
    parameter int unsigned         TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i
);

    localparam int unsigned SW      = DW / 8;
    localparam int unsigned OW      = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_q;
    logic [15:0]     wd_q;
    logic            unmapped_q;
    logic            wd_err_q;

    logic [OW-1:0]   grant;
    logic            grant_vld;
    logic            busy;
    logic [AW-1:0]   owner_adr;
    logic [DW-1:0]   owner_dat;
    logic [SW-1:0]   owner_sel;
    logic            owner_we;
    logic            owner_cyc;
    logic            owner_stb;
    logic [NS-1:0]   sel;
    logic            any_sel;
    logic [DW-1:0]   sl_dat;
    logic            sl_ack;
    logic            sl_err;
    logic            ack;
    logic            err;

    assign busy      = (state_q == StBusy);
    assign owner_adr = m_adr_i[int'(owner_q)*AW +: AW];
    assign owner_dat = m_dat_i[int'(owner_q)*DW +: DW];
    assign owner_sel = m_sel_i[int'(owner_q)*SW +: SW];
    assign owner_we  = m_we_i[owner_q];
    assign owner_cyc = m_cyc_i[owner_q];
    assign owner_stb = m_stb_i[owner_q];

    // Cyclic search starting just after the last owner.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = last_q;
        grant_vld = 1'b0;
        for (int i = 1; i <= int'(NM); i++) begin
            idx = (int'(last_q) + i) % int'(NM);
            if (!grant_vld && m_cyc_i[idx]) begin
                grant_vld = 1'b1;
                grant     = OW'(idx);
            end
        end
    end

    // Lowest matching slave wins; nothing is selected while idle.
    always_comb begin
        sel     = '0;
        any_sel = 1'b0;
        for (int k = 0; k < int'(NS); k++) begin
            if (busy && !any_sel &&
                owner_adr[AW-1 -: DECW] == SLV_ADDRS[k*DECW +: DECW]) begin
                sel[k]  = 1'b1;
                any_sel = 1'b1;
            end
        end
    end

    always_comb begin
        sl_dat = '0;
        sl_ack = 1'b0;
        sl_err = 1'b0;
        for (int k = 0; k < int'(NS); k++) begin
            if (sel[k]) begin
                sl_dat = s_dat_i[k*DW +: DW];
                sl_ack = s_ack_i[k];
                sl_err = s_err_i[k];
            end
        end
    end

    assign ack = busy & owner_stb & sl_ack;
    assign err = busy & owner_stb & (sl_err | unmapped_q | wd_err_q);

    always_comb begin
        m_ack_o          = '0;
        m_err_o          = '0;
        m_ack_o[owner_q] = ack;
        m_err_o[owner_q] = err;
    end

    assign m_dat_o = sl_dat;
    assign s_adr_o = busy ? owner_adr : '0;
    assign s_dat_o = busy ? owner_dat : '0;
    assign s_sel_o = busy ? owner_sel : '0;
    assign s_we_o  = busy & owner_we;
    assign s_cyc_o = sel & {NS{owner_cyc}};
    assign s_stb_o = sel & {NS{owner_stb}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            last_q     <= OW'(NM - 1);
            wd_q       <= '0;
            unmapped_q <= 1'b0;
            wd_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    wd_q       <= '0;
                    unmapped_q <= 1'b0;
                    wd_err_q   <= 1'b0;
                    if (grant_vld) begin
                        state_q <= StBusy;
                        owner_q <= grant;
                        last_q  <= grant;
                    end
                end
                StBusy: begin
                    if (!owner_cyc) begin
                        state_q <= StIdle;
                    end
                    unmapped_q <= owner_stb && !any_sel && !unmapped_q;
                    // An ack in the expiry cycle takes priority over the timeout.
                    if (!owner_stb || ack || err) begin
                        wd_q     <= '0;
                        wd_err_q <= 1'b0;
                    end else if (wd_q == WD_LAST) begin
                        wd_q     <= '0;
                        wd_err_q <= 1'b1;
                    end else begin
                        wd_q     <= wd_q + 16'd1;
                        wd_err_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/wb_conbus_rr.md
# wb_conbus_rr

Parametrised Wishbone shared-bus interconnect with round-robin arbitration, replacing the fixed 2-master / 6-slave bus between the LM32 instruction/data ports and the SoC peripherals (bram, uart, timer, gpio, keypad, SK6812RGBW). It supports any number of masters and slaves, decoded on the top address bits. It adds a bus-error response for unmapped addresses and a watchdog that terminates stalled slave cycles.

## Interface
- NM, 2: number of masters. Index 0 has highest initial priority.
- NS, 6: number of slaves.
- AW, 32: address width.
- DW, 32: data width. Select width is DW/8.
- DECW, 4: number of top address bits decoded.
- SLV_ADDRS, {4'h6,4'h5,4'h4,4'h3,4'h2,4'h0}: flattened NS×DECW decode values. Slave k occupies bits [k*DECW +: DECW].
- TIMEOUT, 255: maximum wait cycles before the watchdog error fires. Range 1..65535.

Ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m_adr_i  in  NM*AW  master addresses
- m_dat_i  in  NM*DW  master write data
- m_sel_i  in  NM*DW/8  master byte selects
- m_we_i  in  NM  master write enables
- m_cyc_i  in  NM  master cycle requests
- m_stb_i  in  NM  master strobes
- m_dat_o  out  DW  read data, broadcast to all masters
- m_ack_o  out  NM  per-master acknowledge
- m_err_o  out  NM  per-master bus error
- s_adr_o  out  AW  shared address
- s_dat_o  out  DW  shared write data
- s_sel_o  out  DW/8  shared byte selects
- s_we_o  out  1  shared write enable
- s_cyc_o  out  NS  per-slave cycle
- s_stb_o  out  NS  per-slave strobe
- s_dat_i  in  NS*DW  slave read data
- s_ack_i  in  NS  slave acknowledges
- s_err_i  in  NS  slave errors. Tie to 0 if a slave has no error output.

## Operation
- **Arbiter FSM, IDLE:**
  - If no m_cyc_i bit is set, stay in IDLE.
  - Otherwise, register a grant to the first requesting master after `last`, searching cyclically (last+1, last+2, …).
  - Move to BUSY, with owner = that master and last = that master.
- **Arbiter FSM, BUSY:**
  - The owner holds the bus while m_cyc_i[owner] = 1. Other requests wait; there is no preemption.
  - When m_cyc_i[owner] = 0, return to IDLE on the next edge. The bus is released for one cycle before the next grant.
- **Shared outputs:** s_adr_o, s_dat_o, s_sel_o and s_we_o are combinational from the owner's inputs. In IDLE they are all 0.
- **Address decode:**
  - hit[k] = (owner adr[AW-1:AW-DECW] == SLV_ADDRS[k]).
  - If several slaves match, the lowest k wins.
  - s_cyc_o[k] = BUSY & m_cyc_i[owner] & sel[k].
  - s_stb_o[k] = BUSY & m_stb_i[owner] & sel[k].
- **Responses:**
  - m_ack_o[owner] = s_ack_i[sel] & m_stb_i[owner].
  - m_err_o[owner] = s_err_i[sel] | unmapped_err | wd_err, gated by m_stb_i[owner].
  - Non-owner ack and err outputs are always 0.
  - m_dat_o = s_dat_i[sel]. It is 0 when no slave is selected.
- **Unmapped access:** stb high with no hit raises a registered unmapped_err. It is a one-cycle pulse, starting the cycle after stb is first seen. No slave strobe is asserted.
- **Watchdog:**
  - 16-bit counter wd.
  - Cleared when stb is low, on any ack or err, or in IDLE.
  - Otherwise increments while the owner's stb is high.
  - When wd == TIMEOUT-1 and no ack arrives, wd_err is registered as a one-cycle pulse and wd clears.
  - Slaves that respond within TIMEOUT cycles are never interrupted.
- **Simultaneous events:**
  - A slave ack arriving in the same cycle as watchdog expiry: ack wins, no error.
  - A slave asserting ack and err together: the master sees both. Masters treat err as dominant.
- **Reset:** rst low clears state to IDLE, last to NM-1 (so master 0 wins first), wd to 0, and both error flags. All outputs go to 0 immediately. A transfer in flight when reset is asserted is abandoned, with no ack or err.

## Timing
- Grant latency: cyc rises in cycle t → s_cyc_o/s_stb_o are visible in cycle t+1.
- Data path: combinational. Ack or read data from the slave reaches the master in the same cycle.
- Bus release: 1 idle cycle between owners. Back-to-back cycles by the same master also pass through IDLE.
- Unmapped error: m_err_o is high in cycle t+2 relative to cyc rise at t.
- Watchdog error: m_err_o is high TIMEOUT cycles after the strobe reaches the slave.
- The only registered outputs are the error pulses. Everything else is combinational from the FSM state and inputs.

## Test plan
- **Single read:** M1 reads 0x30000004; timer slave (k=2) acks after 2 cycles with 0xDEADBEEF.
  - s_stb_o = 6'b000100.
  - m_dat_o = 0xDEADBEEF with m_ack_o = 2'b10.
  - No err.
- **Round robin:** M0 and M1 both raise cyc at reset release, each doing 3 back-to-back single cycles.
  - Grant order is M0, M1, M0, M1, M0, M1.
  - Exactly one idle cycle between owners.
- **Unmapped address:** M0 reads 0x70000000.
  - All s_stb_o bits stay 0.
  - m_err_o[0] pulses for exactly 1 cycle, 2 cycles after cyc rise.
  - m_dat_o = 0.
- **Watchdog:** TIMEOUT = 8, and slave 3 never acks.
  - m_err_o[0] pulses after 8 strobe cycles.
  - Variant: ack arriving at cycle 8 → ack only, no error.
- **Write with byte select:** M1 writes 0x000000AB, sel = 4'b0001, to 0x60000010.
  - s_we_o = 1, s_sel_o = 4'b0001, s_stb_o = 6'b100000.
- **Reset mid-transfer:** rst goes low while M0 is waiting on slave 0.
  - All outputs go to 0 the same cycle.
  - After release, M1 requesting alone is granted within 1 cycle.
